// File: rtl/mem_arbiter.sv
// Round-robin arbiter: fetch (i_*) and load/store (d_*) ports share one req/ack memory; grant-to-mem_req is 1 cycle.
// Losing or later requests wait indefinitely. MEM_ARB_TIMEOUT_EN adds an ack timeout that ends the access with x_err.
module mem_arbiter #(
  parameter int ADDR_W  = 32,
  parameter int DATA_W  = 32,
  parameter int TIMEOUT = 16
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              i_req,
  input  logic [ADDR_W-1:0] i_addr,
  output logic              i_ack,
  output logic [DATA_W-1:0] i_rdata,
  output logic              i_err,
  input  logic              d_req,
  input  logic [ADDR_W-1:0] d_addr,
  input  logic              d_we,
  input  logic [DATA_W-1:0] d_wdata,
  input  logic [1:0]        d_width,
  input  logic              d_extend,
  output logic              d_ack,
  output logic [DATA_W-1:0] d_rdata,
  output logic              d_err,
  output logic              mem_req,
  output logic [ADDR_W-1:0] mem_addr,
  output logic              mem_write,
  output logic [DATA_W-1:0] mem_wdata,
  output logic [1:0]        mem_width,
  output logic              mem_extend,
  input  logic              mem_ack,
  input  logic [DATA_W-1:0] mem_rdata
);

  typedef enum logic [1:0] {IDLE, BUSY_I, BUSY_D} state_t;

  state_t state, state_nxt;
  logic   last, last_nxt;   // 1 = load/store port won most recently
  logic   grant_i, grant_d;
  logic   abort;

`ifdef MEM_ARB_TIMEOUT_EN
  localparam int TW = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
  logic [TW-1:0] tcnt;

  assign abort = (state != IDLE) && !mem_ack && (tcnt == TW'(TIMEOUT - 1));

  always_ff @(posedge clk or posedge reset) begin
    if (reset)
      tcnt <= '0;
    else if (grant_i || grant_d)
      tcnt <= '0;
    else if (state != IDLE && !mem_ack)
      tcnt <= tcnt + 1'b1;
  end
`else
  logic [31:0] unused_timeout;
  assign unused_timeout = 32'(TIMEOUT);
  assign abort = 1'b0;
`endif

  always_comb begin
    state_nxt = state;
    last_nxt  = last;
    grant_i   = 1'b0;
    grant_d   = 1'b0;
    case (state)
      IDLE: begin
        if (i_req && d_req) begin
          grant_i = last;
          grant_d = !last;
        end else begin
          grant_i = i_req;
          grant_d = d_req;
        end
      end
      // the port being acked is never re-granted here; only the other port can take over
      BUSY_I: begin
        if (mem_ack) begin
          if (d_req) grant_d = 1'b1;
          else       state_nxt = IDLE;
        end else if (abort) begin
          state_nxt = IDLE;
        end
      end
      BUSY_D: begin
        if (mem_ack) begin
          if (i_req) grant_i = 1'b1;
          else       state_nxt = IDLE;
        end else if (abort) begin
          state_nxt = IDLE;
        end
      end
      default: state_nxt = IDLE;
    endcase
    if (grant_i) begin
      state_nxt = BUSY_I;
      last_nxt  = 1'b0;
    end
    if (grant_d) begin
      state_nxt = BUSY_D;
      last_nxt  = 1'b1;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state      <= IDLE;
      last       <= 1'b1;
      mem_req    <= 1'b0;
      mem_addr   <= '0;
      mem_write  <= 1'b0;
      mem_wdata  <= '0;
      mem_width  <= 2'b00;
      mem_extend <= 1'b0;
    end else begin
      state <= state_nxt;
      last  <= last_nxt;
      if (grant_i) begin
        mem_req    <= 1'b1;
        mem_addr   <= i_addr;
        mem_write  <= 1'b0;
        mem_wdata  <= '0;
        mem_width  <= 2'b10;
        mem_extend <= 1'b0;
      end else if (grant_d) begin
        mem_req    <= 1'b1;
        mem_addr   <= d_addr;
        mem_write  <= d_we;
        mem_wdata  <= d_wdata;
        mem_width  <= d_width;
        mem_extend <= d_extend;
      end else if (state_nxt == IDLE) begin
        mem_req    <= 1'b0;
      end
    end
  end

  assign i_ack   = (state == BUSY_I) && (mem_ack || abort);
  assign d_ack   = (state == BUSY_D) && (mem_ack || abort);
  assign i_err   = (state == BUSY_I) && abort;
  assign d_err   = (state == BUSY_D) && abort;
  assign i_rdata = mem_rdata;
  assign d_rdata = mem_rdata;

endmodule

// File: tb/tb_mem_arbiter.sv
// Directed bench for mem_arbiter with a byte-addressed memory that acks one cycle after mem_req.
module tb_mem_arbiter;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        i_req = 1'b0;
  logic [31:0] i_addr = '0;
  logic        i_ack;
  logic [31:0] i_rdata;
  logic        i_err;
  logic        d_req = 1'b0;
  logic [31:0] d_addr = '0;
  logic        d_we = 1'b0;
  logic [31:0] d_wdata = '0;
  logic [1:0]  d_width = 2'b00;
  logic        d_extend = 1'b0;
  logic        d_ack;
  logic [31:0] d_rdata;
  logic        d_err;
  logic        mem_req;
  logic [31:0] mem_addr;
  logic        mem_write;
  logic [31:0] mem_wdata;
  logic [1:0]  mem_width;
  logic        mem_extend;
  logic        mem_ack;
  logic [31:0] mem_rdata;

  int checks = 0;
  int errors = 0;

  logic        ack_en = 1'b1;
  logic        stale_ack = 1'b0;
  logic        ack_q;
  logic [31:0] rdata_q;
  logic [7:0]  mem [0:1023];

  always #5 clk = ~clk;

  mem_arbiter #(.ADDR_W(32), .DATA_W(32), .TIMEOUT(4)) dut (
    .clk(clk), .reset(reset),
    .i_req(i_req), .i_addr(i_addr), .i_ack(i_ack), .i_rdata(i_rdata), .i_err(i_err),
    .d_req(d_req), .d_addr(d_addr), .d_we(d_we), .d_wdata(d_wdata), .d_width(d_width),
    .d_extend(d_extend), .d_ack(d_ack), .d_rdata(d_rdata), .d_err(d_err),
    .mem_req(mem_req), .mem_addr(mem_addr), .mem_write(mem_write), .mem_wdata(mem_wdata),
    .mem_width(mem_width), .mem_extend(mem_extend), .mem_ack(mem_ack), .mem_rdata(mem_rdata)
  );

  function automatic logic [31:0] rd(input logic [9:0] a, input logic [1:0] w, input logic x);
    logic [31:0] v;
    v = {mem[a + 10'd3], mem[a + 10'd2], mem[a + 10'd1], mem[a]};
    case (w)
      2'b00:   rd = x ? {{24{v[7]}}, v[7:0]} : {24'b0, v[7:0]};
      2'b01:   rd = x ? {{16{v[15]}}, v[15:0]} : {16'b0, v[15:0]};
      default: rd = v;
    endcase
  endfunction

  assign mem_ack   = ack_q | stale_ack;
  assign mem_rdata = rdata_q;

  always @(posedge clk) begin
    if (reset) begin
      ack_q <= 1'b0;
      rdata_q <= '0;
      mem[10'h100] <= 8'hEF; mem[10'h101] <= 8'hBE; mem[10'h102] <= 8'hAD; mem[10'h103] <= 8'hDE;
      mem[10'h300] <= 8'h78; mem[10'h301] <= 8'h56; mem[10'h302] <= 8'h34; mem[10'h303] <= 8'h12;
    end else if (ack_en && mem_req && !ack_q) begin
      ack_q <= 1'b1;
      if (mem_write) begin
        mem[mem_addr[9:0]] <= mem_wdata[7:0];
        if (mem_width != 2'b00) mem[mem_addr[9:0] + 10'd1] <= mem_wdata[15:8];
        if (mem_width[1]) begin
          mem[mem_addr[9:0] + 10'd2] <= mem_wdata[23:16];
          mem[mem_addr[9:0] + 10'd3] <= mem_wdata[31:24];
        end
      end else begin
        rdata_q <= rd(mem_addr[9:0], mem_width, mem_extend);
      end
    end else begin
      ack_q <= 1'b0;
    end
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  initial begin
    repeat (2) @(negedge clk);
    chk("rst_mem_req", 32'(mem_req), 32'd0);
    chk("rst_mem_addr", mem_addr, 32'd0);
    chk("rst_mem_ctl", 32'({mem_write, mem_width, mem_extend}), 32'd0);
    chk("rst_mem_wdata", mem_wdata, 32'd0);
    chk("rst_acks", 32'({i_ack, d_ack, i_err, d_err}), 32'd0);
    reset = 1'b0;

    // reset in the middle of a load/store access
    ack_en = 1'b0;
    d_req = 1'b1; d_addr = 32'h40; d_we = 1'b0; d_width = 2'b10;
    @(negedge clk);
    chk("t1_busy_req", 32'(mem_req), 32'd1);
    chk("t1_busy_addr", mem_addr, 32'h40);
    reset = 1'b1; d_req = 1'b0;
    #1;
    chk("t1_rst_req", 32'(mem_req), 32'd0);
    chk("t1_rst_dack", 32'(d_ack), 32'd0);
    @(negedge clk);
    reset = 1'b0; ack_en = 1'b1;
    @(negedge clk);
    chk("t1_idle", 32'({mem_req, d_ack}), 32'd0);

    // lone fetch
    i_req = 1'b1; i_addr = 32'h100;
    @(negedge clk);
    chk("t2_req_ctl", 32'({mem_req, mem_write, mem_width, mem_extend}), 32'b1_0_10_0);
    chk("t2_addr", mem_addr, 32'h100);
    chk("t2_no_ack_yet", 32'(i_ack), 32'd0);
    @(negedge clk);
    chk("t2_iack", 32'({i_ack, i_err, d_ack}), 32'b100);
    chk("t2_irdata", i_rdata, 32'hDEADBEEF);
    i_req = 1'b0;
    @(negedge clk);
    chk("t2_done", 32'({mem_req, i_ack}), 32'd0);
    stale_ack = 1'b1;
    #1;
    chk("t2_stale_ack", 32'({i_ack, d_ack}), 32'd0);
    @(negedge clk);
    stale_ack = 1'b0;
    chk("t2_stale_idle", 32'(mem_req), 32'd0);

    // byte store then sign-extended byte load
    d_req = 1'b1; d_addr = 32'h203; d_we = 1'b1; d_wdata = 32'hA5; d_width = 2'b00; d_extend = 1'b0;
    @(negedge clk);
    chk("t3_st_ctl", 32'({mem_req, mem_write, mem_width}), 32'b1100);
    chk("t3_st_addr", mem_addr, 32'h203);
    chk("t3_st_wdata", mem_wdata, 32'hA5);
    @(negedge clk);
    chk("t3_st_ack", 32'({d_ack, d_err}), 32'b10);
    d_req = 1'b0;
    @(negedge clk);
    chk("t3_st_done", 32'(mem_req), 32'd0);
    d_req = 1'b1; d_we = 1'b0; d_wdata = '0; d_extend = 1'b1;
    @(negedge clk);
    chk("t3_ld_ctl", 32'({mem_req, mem_write, mem_extend}), 32'b101);
    @(negedge clk);
    chk("t3_ld_ack", 32'(d_ack), 32'd1);
    chk("t3_ld_rdata", d_rdata, 32'hFFFFFFA5);
    d_req = 1'b0; d_extend = 1'b0;
    @(negedge clk);

    // both ports held from reset: alternate I, D, I
    reset = 1'b1;
    i_req = 1'b1; i_addr = 32'h100;
    d_req = 1'b1; d_addr = 32'h300; d_we = 1'b0; d_width = 2'b10;
    repeat (2) @(negedge clk);
    reset = 1'b0;
    @(negedge clk);
    chk("t4_g1_addr", mem_addr, 32'h100);
    chk("t4_g1_req", 32'(mem_req), 32'd1);
    @(negedge clk);
    chk("t4_a1_acks", 32'({i_ack, d_ack}), 32'b10);
    chk("t4_a1_rdata", i_rdata, 32'hDEADBEEF);
    @(negedge clk);
    chk("t4_g2_addr", mem_addr, 32'h300);
    chk("t4_g2_state", 32'({mem_req, i_ack, d_ack}), 32'b100);
    @(negedge clk);
    chk("t4_a2_acks", 32'({i_ack, d_ack}), 32'b01);
    chk("t4_a2_rdata", d_rdata, 32'h12345678);
    @(negedge clk);
    chk("t4_g3_addr", mem_addr, 32'h100);
    @(negedge clk);
    chk("t4_a3_acks", 32'({i_ack, d_ack}), 32'b10);
    i_req = 1'b0; d_req = 1'b0;
    @(negedge clk);
    chk("t4_idle", 32'(mem_req), 32'd0);

    // same port repeating: gap cycle, acks 3 cycles apart
    d_req = 1'b1; d_addr = 32'h300;
    @(negedge clk);
    chk("t5_g1", 32'(mem_req), 32'd1);
    @(negedge clk);
    chk("t5_a1", 32'(d_ack), 32'd1);
    chk("t5_a1_rdata", d_rdata, 32'h12345678);
    @(negedge clk);
    chk("t5_gap", 32'({mem_req, d_ack}), 32'd0);
    @(negedge clk);
    chk("t5_g2", 32'({mem_req, d_ack}), 32'b10);
    @(negedge clk);
    chk("t5_a2", 32'(d_ack), 32'd1);
    d_req = 1'b0;
    @(negedge clk);
    chk("t5_idle", 32'(mem_req), 32'd0);

`ifdef MEM_ARB_TIMEOUT_EN
    // memory never answers: abort on the 4th busy cycle
    ack_en = 1'b0;
    d_req = 1'b1;
    @(negedge clk);
    chk("t6_busy", 32'(mem_req), 32'd1);
    repeat (2) @(negedge clk);
    chk("t6_no_abort_yet", 32'({d_ack, d_err}), 32'd0);
    @(negedge clk);
    chk("t6_abort", 32'({d_ack, d_err, i_ack}), 32'b110);
    d_req = 1'b0;
    @(negedge clk);
    chk("t6_idle", 32'({mem_req, d_ack}), 32'd0);
    stale_ack = 1'b1;
    #1;
    chk("t6_late_ack", 32'({d_ack, d_err}), 32'd0);
    @(negedge clk);
    stale_ack = 1'b0; ack_en = 1'b1;
    chk("t6_late_idle", 32'(mem_req), 32'd0);
`endif

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
